// File: rtl/cmem_reader_pkg.sv
// Shared definitions for the layer-result memory read-back engine:
// memory select encodings (common with the writer side), default widths
// and the sweep FSM state encoding.
package cmem_reader_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 20;
  localparam int FIFO_DEPTH_DEF = 4;

  // Memory select encodings, identical to the cwr/csel writer path
  localparam logic [2:0] SEL_L0 = 3'd1;
  localparam logic [2:0] SEL_L1 = 3'd3;
  localparam logic [2:0] SEL_L2 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cmem_reader_if.sv
// Bus bundle of the reader: the memory read port (crd/caddr_rd/cdata_rd/csel)
// and the tagged output stream (o_valid/i_ready/o_data/o_addr).
//
// Stream handshake: a word transfers on every rising clk edge where
// o_valid & i_ready are both 1. Once o_valid is raised, o_valid, o_data and
// o_addr hold their values until that transfer happens. o_valid never
// depends combinationally on i_ready.
interface cmem_reader_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20
);
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [DATA_W-1:0] cdata_rd;
  logic [2:0]        csel;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W-1:0] o_addr;

  modport master (
    output crd, caddr_rd, csel, o_valid, o_data, o_addr,
    input  cdata_rd, i_ready
  );

  modport slave (
    input  crd, caddr_rd, csel, o_valid, o_data, o_addr,
    output cdata_rd, i_ready
  );
endinterface

// File: rtl/cmem_reader_fifo.sv
// Small synchronous FIFO buffering {data, address} words between the memory
// read port and the output stream. Pushes into a full FIFO and pops from an
// empty one are dropped so the pointers can never be corrupted.
module cmem_reader_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cmem_reader.sv
// Read-back engine: on i_start, sweeps i_len words of the selected layer
// memory from i_base (wrapping at the top of the address space) and emits
// each word with its source address on the output stream.
module cmem_reader
  import cmem_reader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic [2:0]        i_sel,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  output logic              o_busy,
  output logic              o_done,
  output state_t            o_state,
  cmem_reader_if.master     bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = DATA_W + ADDR_W;

  state_t            state_q, state_d;
  logic [2:0]        sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic              crd;
  logic              credit_ok;
  logic              valid;
  logic              pop;
  logic [FW-1:0]     fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;

  // A read may only be issued if the FIFO can absorb every word already owed
  assign credit_ok = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(FIFO_DEPTH);
  assign valid     = !fifo_empty;
  assign pop       = valid && bus.i_ready;

  // Next state and per-state outputs
  always_comb begin
    state_d = state_q;
    crd     = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = (i_len == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        o_busy = 1'b1;
        if (credit_ok) begin
          crd = 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        // Finish in the cycle the last word leaves so o_done follows it directly
        if (!inflight_q && (fifo_empty || (fifo_count == CW'(1) && pop)))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep registers: command latch, address/remaining counters, in-flight tag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= crd;
      if (crd) begin
        rd_addr_q <= addr_q;
        addr_q    <= addr_q + ADDR_W'(1);
        rem_q     <= rem_q - (ADDR_W+1)'(1);
      end
      if (state_q == ST_IDLE && i_start) begin
        sel_q  <= i_sel;
        addr_q <= i_base;
        rem_q  <= i_len;
      end
    end
  end

  // Read data returns one cycle after crd and is tagged with its address
  cmem_reader_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({bus.cdata_rd, rd_addr_q}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign bus.crd      = crd;
  assign bus.caddr_rd = crd ? addr_q : '0;
  assign bus.csel     = sel_q;
  assign bus.o_valid  = valid;
  assign bus.o_data   = valid ? fifo_dout[FW-1:ADDR_W] : '0;
  assign bus.o_addr   = valid ? fifo_dout[ADDR_W-1:0] : '0;
  assign o_state      = state_q;

endmodule

// File: tb/tb_cmem_reader.sv
// Bench for cmem_reader: random-content memory model, stream monitor and
// per-scenario tasks comparing against an address-order reference stream.
module tb_cmem_reader;
  import cmem_reader_pkg::*;

  localparam int AW = 12;
  localparam int DW = 20;
  localparam int W  = DW + AW;
  localparam int NWORDS = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          i_start = 1'b0;
  logic [2:0]    i_sel = '0;
  logic [AW-1:0] i_base = '0;
  logic [AW:0]   i_len = '0;
  logic          o_busy, o_done;
  state_t        o_state;

  cmem_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  cmem_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_start (i_start),
    .i_sel   (i_sel),
    .i_base  (i_base),
    .i_len   (i_len),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_state (o_state),
    .bus     (bus)
  );

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [NWORDS];
  always @(posedge clk) if (bus.crd) bus.cdata_rd <= mem[bus.caddr_rd];

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  int            obs_cyc_q[$];
  logic [AW-1:0] crd_addr_q[$];
  int            crd_cyc_q[$];
  int            done_cyc_q[$];
  logic          done_busy_q[$];
  logic [2:0]    exp_sel = '0;
  bit            busy_seen = 0;
  int            csel_bad = 0;

  // Monitor: records read strobes, stream transfers and done pulses
  always @(negedge clk) begin
    if (bus.crd) begin
      crd_addr_q.push_back(bus.caddr_rd);
      crd_cyc_q.push_back(cyc);
    end
    if (bus.o_valid && bus.i_ready) begin
      obs_q.push_back({bus.o_data, bus.o_addr});
      obs_cyc_q.push_back(cyc);
    end
    if (o_done) begin
      done_cyc_q.push_back(cyc);
      done_busy_q.push_back(o_busy);
    end
    if (o_busy) busy_seen = 1;
    if (o_busy && bus.csel !== exp_sel) csel_bad++;
    if (reset && dut.u_fifo.push && dut.u_fifo.full) begin
      n_total++;
      $display("FAIL fifo_overflow: push into full FIFO at cycle %0d (required never)", cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    exp_q.delete(); obs_q.delete(); obs_cyc_q.delete();
    crd_addr_q.delete(); crd_cyc_q.delete();
    done_cyc_q.delete(); done_busy_q.delete();
    busy_seen = 0; csel_bad = 0;
  endtask

  // Pulse i_start for one cycle; reference stream is base, base+1, ... mod 4096
  task automatic start_sweep(input logic [2:0] sel, input logic [AW-1:0] base,
                             input int len, output int t);
    @(posedge clk); #1;
    i_start = 1'b1; i_sel = sel; i_base = base; i_len = (AW+1)'(len);
    t = cyc;
    exp_sel = sel;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (int'(base) + i) % NWORDS;
      exp_q.push_back({mem[a], AW'(a)});
    end
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (o_done) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({bus.crd, bus.caddr_rd, bus.csel, bus.o_valid, bus.o_data, bus.o_addr, o_busy, o_done} !== '0)
      $display("FAIL reset_outputs: got crd=%0d addr=%0h csel=%0d valid=%0d data=%0h oaddr=%0h busy=%0d done=%0d required all 0",
               bus.crd, bus.caddr_rd, bus.csel, bus.o_valid, bus.o_data, bus.o_addr, o_busy, o_done);
    else n_pass++;
    n_total++;
    if (o_state !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", o_state, ST_IDLE);
    else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int t; bit ok; int last;
    clear_mon(); bus.i_ready = 1'b1;
    start_sweep(SEL_L0, 12'd0, 8, t);
    wait_done(100, ok);
    n_total++;
    if (!ok) $display("FAIL basic_done: got no o_done required pulse"); else n_pass++;
    n_total++;
    if (crd_cyc_q.size() != 8) $display("FAIL basic_crd_count: got %0d required 8", crd_cyc_q.size());
    else n_pass++;
    n_total++;
    if (crd_cyc_q.size() == 0 || crd_cyc_q[0] != t + 1)
      $display("FAIL basic_crd_latency: got %0d required %0d", crd_cyc_q.size() ? crd_cyc_q[0] : -1, t + 1);
    else n_pass++;
    n_total++;
    if (obs_q.size() != 8) $display("FAIL basic_word_count: got %0d required 8", obs_q.size());
    else n_pass++;
    for (int i = 0; i < obs_q.size() && i < 8; i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i] || obs_cyc_q[i] != t + 3 + i)
        $display("FAIL basic_word%0d: got %0h at cycle %0d required %0h at cycle %0d",
                 i, obs_q[i], obs_cyc_q[i], exp_q[i], t + 3 + i);
      else n_pass++;
    end
    last = obs_cyc_q.size() ? obs_cyc_q[obs_cyc_q.size()-1] : -10;
    n_total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != last + 1)
      $display("FAIL basic_done_timing: got %0d pulses first at %0d required 1 at %0d",
               done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] : -1, last + 1);
    else n_pass++;
    n_total++;
    if (done_busy_q.size() == 0 || done_busy_q[0] !== 1'b0)
      $display("FAIL basic_busy_at_done: got %0d required 0", done_busy_q.size() ? done_busy_q[0] : 1'bx);
    else n_pass++;
    n_total++;
    if (csel_bad != 0) $display("FAIL basic_csel: got %0d wrong cycles required 0", csel_bad);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int t; bit ok; logic [AW-1:0] want;
    clear_mon(); bus.i_ready = 1'b1;
    start_sweep(SEL_L1, 12'd4094, 4, t);
    wait_done(100, ok);
    n_total++;
    if (!ok || crd_addr_q.size() != 4) $display("FAIL wrap_reads: got %0d reads done=%0d required 4 reads", crd_addr_q.size(), ok);
    else n_pass++;
    for (int i = 0; i < crd_addr_q.size() && i < 4; i++) begin
      want = AW'((4094 + i) % NWORDS);
      n_total++;
      if (crd_addr_q[i] !== want) $display("FAIL wrap_caddr%0d: got %0d required %0d", i, crd_addr_q[i], want);
      else n_pass++;
    end
    n_total++;
    if (obs_q != exp_q) $display("FAIL wrap_stream: got %0d words required %0d matching words", obs_q.size(), exp_q.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int t; bit ok; bit done_hit; bit prev_stall; logic [W-1:0] prev;
    logic [3:0] pat; int bad;
    pat = 4'b1001;
    clear_mon(); bus.i_ready = 1'b1;
    start_sweep(SEL_L2, 12'd10, 16, t);
    done_hit = 0; prev_stall = 0; prev = '0; bad = 0;
    for (int k = 0; k < 300 && !done_hit; k++) begin
      bus.i_ready = pat[k % 4];
      @(negedge clk);
      if (prev_stall && !(bus.o_valid && {bus.o_data, bus.o_addr} == prev)) begin
        bad++;
        $display("FAIL stall_stable: got valid=%0d word=%0h required valid=1 word=%0h", bus.o_valid, {bus.o_data, bus.o_addr}, prev);
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev = {bus.o_data, bus.o_addr};
      if (o_done) done_hit = 1;
      @(posedge clk); #1;
    end
    n_total++;
    if (bad != 0 || !done_hit) $display("FAIL bp_toggle: got %0d stall errors done=%0d required 0 errors and done", bad, done_hit);
    else n_pass++;
    n_total++;
    if (obs_q != exp_q) $display("FAIL bp_toggle_stream: got %0d words required %0d matching", obs_q.size(), exp_q.size());
    else n_pass++;

    clear_mon(); bus.i_ready = 1'b0;
    start_sweep(SEL_L0, 12'd300, 16, t);
    repeat (20) @(posedge clk);
    #1;
    n_total++;
    if (crd_cyc_q.size() != 4) $display("FAIL bp_credit: got %0d reads required 4", crd_cyc_q.size());
    else n_pass++;
    n_total++;
    if (bus.o_valid !== 1'b1 || obs_q.size() != 0) $display("FAIL bp_hold: got valid=%0d popped=%0d required 1 and 0", bus.o_valid, obs_q.size());
    else n_pass++;
    bus.i_ready = 1'b1;
    wait_done(200, ok);
    n_total++;
    if (!ok || obs_q != exp_q) $display("FAIL bp_stall_stream: got %0d words done=%0d required %0d matching", obs_q.size(), ok, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_zero_len();
    int t; bit ok;
    clear_mon(); bus.i_ready = 1'b1;
    start_sweep(SEL_L2, 12'd5, 0, t);
    wait_done(10, ok);
    n_total++;
    if (!ok || done_cyc_q.size() != 1 || done_cyc_q[0] != t + 1)
      $display("FAIL zero_done: got %0d pulses first at %0d required 1 at %0d",
               done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] : -1, t + 1);
    else n_pass++;
    n_total++;
    if (crd_cyc_q.size() != 0 || busy_seen || obs_q.size() != 0)
      $display("FAIL zero_activity: got reads=%0d busy=%0d words=%0d required 0 0 0", crd_cyc_q.size(), busy_seen, obs_q.size());
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int t; bit ok;
    clear_mon(); bus.i_ready = 1'b1;
    start_sweep(SEL_L1, 12'd200, 10, t);
    repeat (3) @(posedge clk);
    #1;
    i_start = 1'b1; i_sel = SEL_L2; i_base = 12'd900; i_len = 13'd3;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_done(100, ok);
    repeat (10) @(posedge clk);
    #1;
    n_total++;
    if (!ok || obs_q != exp_q) $display("FAIL busy_start_stream: got %0d words done=%0d required %0d matching", obs_q.size(), ok, exp_q.size());
    else n_pass++;
    n_total++;
    if (csel_bad != 0 || crd_cyc_q.size() != 10) $display("FAIL busy_start_csel: got %0d bad csel cycles %0d reads required 0 and 10", csel_bad, crd_cyc_q.size());
    else n_pass++;
    n_total++;
    if (o_state !== ST_IDLE || done_cyc_q.size() != 1) $display("FAIL busy_start_idle: got state %0d dones %0d required %0d and 1", o_state, done_cyc_q.size(), ST_IDLE);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int t; bit ok;
    clear_mon(); bus.i_ready = 1'b0;
    start_sweep(SEL_L0, 12'd40, 16, t);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (bus.o_valid !== 1'b1 || dut.u_fifo.count != 2) $display("FAIL rstmid_setup: got valid=%0d count=%0d required 1 and 2", bus.o_valid, dut.u_fifo.count);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({bus.crd, bus.caddr_rd, bus.csel, bus.o_valid, bus.o_data, bus.o_addr, o_busy, o_done} !== '0 || o_state !== ST_IDLE)
      $display("FAIL rstmid_outputs: got crd=%0d csel=%0d valid=%0d busy=%0d state=%0d required all 0",
               bus.crd, bus.csel, bus.o_valid, o_busy, o_state);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b1;
    n_total++;
    if (done_cyc_q.size() != 0) $display("FAIL rstmid_no_done: got %0d pulses required 0", done_cyc_q.size());
    else n_pass++;
    clear_mon(); bus.i_ready = 1'b1;
    start_sweep(SEL_L0, 12'd100, 2, t);
    wait_done(50, ok);
    n_total++;
    if (!ok || obs_q.size() != 2 || obs_q != exp_q)
      $display("FAIL rstmid_resweep: got %0d words done=%0d required 2 words at 100,101", obs_q.size(), ok);
    else n_pass++;
  endtask

  task automatic test_random();
    int t; int len; int bad; bit done_hit;
    logic [2:0] sel; logic [AW-1:0] base;
    for (int it = 0; it < 5; it++) begin
      clear_mon(); bus.i_ready = 1'b1;
      len  = (it == 4) ? NWORDS : $urandom_range(1, 40);
      base = AW'($urandom_range(0, NWORDS - 1));
      case ($urandom_range(0, 2))
        0:       sel = SEL_L0;
        1:       sel = SEL_L1;
        default: sel = SEL_L2;
      endcase
      start_sweep(sel, base, len, t);
      done_hit = 0;
      for (int k = 0; k < 3 * len + 50 && !done_hit; k++) begin
        bus.i_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (o_done) done_hit = 1;
        @(posedge clk); #1;
      end
      bad = 0;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
        if (obs_q[i] !== exp_q[i]) bad++;
      n_total++;
      if (!done_hit || obs_q.size() != exp_q.size() || bad != 0)
        $display("FAIL random%0d: got %0d words %0d wrong done=%0d required %0d words 0 wrong (base %0d)",
                 it, obs_q.size(), bad, done_hit, exp_q.size(), base);
      else n_pass++;
      n_total++;
      if (csel_bad != 0) $display("FAIL random%0d_csel: got %0d bad cycles required 0", it, csel_bad);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NWORDS; i++) mem[i] = DW'($urandom());
    bus.i_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
